// File: rtl/jt6295_rom_arb.sv
// Three-way arbiter for the single external ADPCM ROM port.
// Each slot gets a cs/addr -> dout/ok handshake; one fetch runs at a time.
module jt6295_rom_slot #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          grant,
    input  logic          serve,
    input  logic [7:0]    rom_data,
    output logic [7:0]    dout,
    output logic          ok,
    output logic          pending,
    output logic          match
);
    logic [AW-1:0] ok_addr;
    logic          same;

    assign same    = (addr == ok_addr);
    assign pending = cs && (!ok || !same);
    // The slot still wants exactly the address being fetched for it
    assign match   = cs && same;

    always_ff @(posedge clk) begin
        if (rst) begin
            ok_addr <= '0;
            dout    <= 8'd0;
            ok      <= 1'b0;
        end else begin
            if (grant) ok_addr <= addr;
            if (serve) begin
                dout <= rom_data;
                ok   <= 1'b1;
            end else if (!cs || !same) begin
                ok <= 1'b0;
            end
        end
    end
endmodule

module jt6295_rom_arb #(
    parameter int AW        = 18,
    parameter int FIXED_PRI = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          slot0_cs,
    input  logic [AW-1:0] slot0_addr,
    output logic [7:0]    slot0_dout,
    output logic          slot0_ok,
    input  logic          slot1_cs,
    input  logic [AW-1:0] slot1_addr,
    output logic [7:0]    slot1_dout,
    output logic          slot1_ok,
    input  logic          slot2_cs,
    input  logic [AW-1:0] slot2_addr,
    output logic [7:0]    slot2_dout,
    output logic          slot2_ok,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    logic [1:0]           st;
    logic [1:0]           win;
    logic [1:0]           ptr;
    logic [2:0]           slot_cs;
    logic [2:0][AW-1:0]   slot_addr;
    logic [2:0][7:0]      slot_dout;
    logic [2:0]           slot_ok;
    logic [2:0]           pending;
    logic [2:0]           match;
    logic [2:0]           grant;
    logic [2:0]           serve;
    logic [1:0]           pick;
    logic [1:0]           nxt_ptr;
    logic                 found;
    int                   idx;

    assign slot_cs   = {slot2_cs, slot1_cs, slot0_cs};
    assign slot_addr = {slot2_addr, slot1_addr, slot0_addr};
    assign slot0_dout = slot_dout[0];
    assign slot1_dout = slot_dout[1];
    assign slot2_dout = slot_dout[2];
    assign slot0_ok   = slot_ok[0];
    assign slot1_ok   = slot_ok[1];
    assign slot2_ok   = slot_ok[2];

    // Winner search: from the pointer with wrap, or from slot0 in fixed mode
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < 3; k++) begin
            idx = (FIXED_PRI != 0) ? k : (int'(ptr) + k) % 3;
            if (!found && pending[2'(idx)]) begin
                found = 1'b1;
                pick  = 2'(idx);
            end
        end
    end

    assign nxt_ptr = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
    assign grant   = (st == IDLE && found) ? (3'b001 << pick) : 3'b000;
    assign serve   = (st == WAIT && match[win] && rom_ok) ? (3'b001 << win) : 3'b000;

    for (genvar g = 0; g < 3; g++) begin : g_slot
        jt6295_rom_slot #(.AW(AW)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .cs       (slot_cs[g]),
            .addr     (slot_addr[g]),
            .grant    (grant[g]),
            .serve    (serve[g]),
            .rom_data (rom_data),
            .dout     (slot_dout[g]),
            .ok       (slot_ok[g]),
            .pending  (pending[g]),
            .match    (match[g])
        );
    end

    // SETTLE masks rom_ok that still belongs to the previous address
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            win      <= 2'd0;
            ptr      <= 2'd0;
            rom_addr <= '0;
            rom_cs   <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (found) begin
                        rom_addr <= slot_addr[pick];
                        rom_cs   <= 1'b1;
                        win      <= pick;
                        ptr      <= nxt_ptr;
                        st       <= SETTLE;
                    end
                end
                SETTLE: st <= WAIT;
                WAIT: begin
                    if (!match[win] || rom_ok) begin
                        rom_cs <= 1'b0;
                        st     <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Bench for jt6295_rom_arb: round-robin and fixed-priority instances run
// side by side against a cycle model plus directed constant checks.
module tb_jt6295_rom_arb;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rom_ok = 1'b0;
    always #5 clk = ~clk;

    logic          cs       [2][3];
    logic [AW-1:0] addr     [2][3];
    logic [7:0]    dout     [2][3];
    logic          ok       [2][3];
    logic [AW-1:0] rom_addr [2];
    logic          rom_cs   [2];
    logic [7:0]    rom_data [2];
    logic [7:0]    mem      [1024];

    int checks = 0;
    int failures = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        assign rom_data[gi] = mem[rom_addr[gi][9:0]];
        jt6295_rom_arb #(.AW(AW), .FIXED_PRI(gi)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .slot0_cs   (cs[gi][0]),
            .slot0_addr (addr[gi][0]),
            .slot0_dout (dout[gi][0]),
            .slot0_ok   (ok[gi][0]),
            .slot1_cs   (cs[gi][1]),
            .slot1_addr (addr[gi][1]),
            .slot1_dout (dout[gi][1]),
            .slot1_ok   (ok[gi][1]),
            .slot2_cs   (cs[gi][2]),
            .slot2_addr (addr[gi][2]),
            .slot2_dout (dout[gi][2]),
            .slot2_ok   (ok[gi][2]),
            .rom_addr   (rom_addr[gi]),
            .rom_cs     (rom_cs[gi]),
            .rom_data   (rom_data[gi]),
            .rom_ok     (rom_ok)
        );
    end

    // Reference model: per-slot served address/data, one fetch in flight,
    // aged in cycles since the grant.
    bit            m_ok    [2][3];
    logic [AW-1:0] m_sa    [2][3];
    logic [7:0]    m_dout  [2][3];
    bit            m_busy  [2];
    int            m_age   [2];
    int            m_w     [2];
    int            m_ptr   [2];
    logic [AW-1:0] m_raddr [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int n = 0; n < 3; n++) begin
                    m_ok[i][n] = 1'b0; m_sa[i][n] = '0; m_dout[i][n] = 8'd0;
                end
                m_busy[i] = 1'b0; m_age[i] = 0; m_w[i] = 0; m_ptr[i] = 0; m_raddr[i] = '0;
            end else begin
                bit pend [3];
                int w;
                int c;
                for (int n = 0; n < 3; n++)
                    pend[n] = cs[i][n] && !(m_ok[i][n] && addr[i][n] == m_sa[i][n]);
                for (int n = 0; n < 3; n++)
                    if (!cs[i][n] || addr[i][n] != m_sa[i][n]) m_ok[i][n] = 1'b0;
                if (m_busy[i]) begin
                    m_age[i]++;
                    w = m_w[i];
                    if (m_age[i] >= 2) begin
                        if (!cs[i][w] || addr[i][w] != m_sa[i][w]) begin
                            m_busy[i] = 1'b0;
                        end else if (rom_ok) begin
                            m_dout[i][w] = mem[m_sa[i][w][9:0]];
                            m_ok[i][w] = 1'b1;
                            m_busy[i] = 1'b0;
                        end
                    end
                end else begin
                    w = -1;
                    for (int k = 0; k < 3; k++) begin
                        c = (i == 1) ? k : (m_ptr[i] + k) % 3;
                        if (w < 0 && pend[c]) w = c;
                    end
                    if (w >= 0) begin
                        m_sa[i][w] = addr[i][w];
                        m_raddr[i] = addr[i][w];
                        m_busy[i] = 1'b1;
                        m_age[i] = 0;
                        m_w[i] = w;
                        m_ptr[i] = (w + 1) % 3;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 3; n++) begin
                chk($sformatf("dout_i%0d_s%0d", i, n), dout[i][n], m_dout[i][n]);
                chk($sformatf("ok_i%0d_s%0d", i, n), ok[i][n], m_ok[i][n]);
            end
            chk($sformatf("rom_addr_i%0d", i), rom_addr[i], m_raddr[i]);
            chk($sformatf("rom_cs_i%0d", i), rom_cs[i], m_busy[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_slot(input int n, input bit c, input logic [AW-1:0] a);
        for (int i = 0; i < 2; i++) begin
            cs[i][n] = c;
            addr[i][n] = a;
        end
    endtask

    logic [AW-1:0] gq [2][$];
    bit prev_ok [2][3];
    bit prev_cs [2];

    initial begin
        for (int j = 0; j < 1024; j++) mem[j] = 8'($urandom);
        mem[16] = 8'h5A; mem[64] = 8'h11; mem[65] = 8'h22;
        for (int n = 0; n < 3; n++) set_slot(n, 1'b0, '0);

        // Reset state
        tick(); tick();
        chk("rst_rom_cs", rom_cs[0], 0);
        chk("rst_rom_addr", rom_addr[0], 0);
        chk("rst_ok1", ok[0][1], 0);
        chk("rst_dout1", dout[0][1], 0);

        // Single fetch, rom_ok held high
        rst = 1'b0; rom_ok = 1'b1;
        set_slot(1, 1'b1, 18'h00010);
        tick();
        chk("single_rom_addr", rom_addr[0], 18'h10);
        chk("single_rom_cs", rom_cs[0], 1);
        tick();
        chk("single_ok_early", ok[0][1], 0);
        tick();
        chk("single_ok", ok[0][1], 1);
        chk("single_dout", dout[0][1], 8'h5A);
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("single_hold_cs", rom_cs[0], 0);
            chk("single_hold_ok", ok[0][1], 1);
        end
        set_slot(1, 1'b0, 18'h00010);
        tick();

        // Stale ok during SETTLE must not latch
        set_slot(2, 1'b1, 18'h00020);
        tick();
        tick();
        rom_ok = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("stale_ok_low", ok[0][2], 0);
        end
        rom_ok = 1'b1;
        tick();
        chk("stale_ok", ok[0][2], 1);
        chk("stale_dout", dout[0][2], mem[32]);
        set_slot(2, 1'b0, 18'h00020);
        tick();

        // Round-robin vs fixed priority with continuous requests
        set_slot(0, 1'b1, 18'h100); set_slot(1, 1'b1, 18'h200); set_slot(2, 1'b1, 18'h300);
        for (int i = 0; i < 2; i++) begin
            prev_cs[i] = rom_cs[i];
            for (int n = 0; n < 3; n++) prev_ok[i][n] = ok[i][n];
        end
        for (int t = 0; t < 40; t++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (rom_cs[i] && !prev_cs[i]) gq[i].push_back(rom_addr[i]);
                prev_cs[i] = rom_cs[i];
                for (int n = 0; n < 3; n++) begin
                    if (ok[i][n] && !prev_ok[i][n]) addr[i][n] = addr[i][n] + 1'b1;
                    prev_ok[i][n] = ok[i][n];
                end
            end
        end
        chk("rr_grant_count_ok", gq[0].size() >= 9, 1);
        chk("fix_grant_count_ok", gq[1].size() >= 6, 1);
        for (int j = 0; j < 9 && j < gq[0].size(); j++)
            chk($sformatf("rr_grant%0d", j), gq[0][j], 32'((j % 3 + 1) * 'h100 + j / 3));
        for (int j = 0; j < 6 && j < gq[1].size(); j++)
            chk($sformatf("fix_grant%0d", j), gq[1][j], 32'('h100 + j));
        for (int n = 0; n < 3; n++) set_slot(n, 1'b0, '0);
        repeat (4) tick();

        // Abort on address change during WAIT
        rom_ok = 1'b0;
        set_slot(0, 1'b1, 18'h40);
        tick(); tick(); tick();
        chk("abort_rom_addr0", rom_addr[0], 18'h40);
        set_slot(0, 1'b1, 18'h41);
        tick();
        chk("abort_rom_cs", rom_cs[0], 0);
        chk("abort_ok", ok[0][0], 0);
        rom_ok = 1'b1;
        tick();
        chk("abort_rom_addr1", rom_addr[0], 18'h41);
        tick(); tick();
        chk("abort_ok_after", ok[0][0], 1);
        chk("abort_dout", dout[0][0], 8'h22);
        set_slot(0, 1'b0, 18'h41);
        tick();

        // Reset mid-fetch
        rom_ok = 1'b0;
        set_slot(1, 1'b1, 18'h55);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("midrst_rom_cs", rom_cs[0], 0);
        chk("midrst_rom_addr", rom_addr[0], 0);
        chk("midrst_ok1", ok[0][1], 0);
        chk("midrst_dout0", dout[0][0], 0);
        chk("midrst_dout2", dout[0][2], 0);
        rst = 1'b0; rom_ok = 1'b1;
        tick(); tick(); tick();
        chk("midrst_refetch_ok", ok[0][1], 1);
        chk("midrst_refetch_dout", dout[0][1], mem['h55]);

        // Random traffic against the model
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < 2; i++)
                for (int n = 0; n < 3; n++) begin
                    if ($urandom % 8 == 0) cs[i][n] = ~cs[i][n];
                    if ($urandom % 6 == 0) addr[i][n] = AW'((n + 1) * 'h100 + $urandom % 8);
                end
            rom_ok = ($urandom % 3) != 0;
            rst = ($urandom % 150) == 0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
